// File: rtl/opl3_vib_sequencer.sv
// Sequences every OPL3 operator through the shared vibrato datapath once per
// sample frame and writes each operator's vibrato offset into the result buffer.
// The LFO advances only at frame end, so all operators in a frame share one phase.
module opl3_vib_sequencer #(
  parameter int unsigned NUM_OPS        = 36,
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned VIB_LAT        = 2,
  parameter int unsigned REG_FNUM_WIDTH = 10,
  parameter int unsigned VIB_VAL_WIDTH  = 4,
  localparam int unsigned ADDR_W        = $clog2(NUM_OPS)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_sample_clk_en,
  input  logic                      i_dvb,
  output logic                      o_reg_rd_en,
  output logic [ADDR_W-1:0]         o_reg_rd_addr,
  input  logic [REG_FNUM_WIDTH-1:0] i_reg_rd_fnum,
  input  logic                      i_reg_rd_vib,
  output logic [REG_FNUM_WIDTH-1:0] o_vib_fnum,
  output logic                      o_vib_dvb,
  output logic                      o_vib_lfo_step,
  input  logic [VIB_VAL_WIDTH-1:0]  i_vib_val,
  output logic                      o_res_wr_en,
  output logic [ADDR_W-1:0]         o_res_wr_addr,
  output logic [VIB_VAL_WIDTH-1:0]  o_res_wr_data,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic                      o_overrun
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                      r_state;
  logic                        r_rd_en;
  logic [ADDR_W-1:0]           r_rd_addr;
  logic                        r_dvb;
  logic                        r_busy;
  logic                        r_frame_done;
  logic                        r_lfo_step;
  logic                        r_overrun;

  // Read-return alignment pipe (covers register-file latency)
  logic [RD_LAT-1:0]             r_ret_v;
  logic [RD_LAT-1:0][ADDR_W-1:0] r_ret_idx;

  // Stage 1: registered operand for the vibrato datapath
  logic                        r_s1_v;
  logic [ADDR_W-1:0]           r_s1_idx;
  logic                        r_s1_vib;
  logic                        r_s1_dvb;
  logic [REG_FNUM_WIDTH-1:0]   r_s1_fnum;

  // Tag pipe aligned with the vibrato datapath result
  logic [VIB_LAT-1:0]             r_tag_v;
  logic [VIB_LAT-1:0]             r_tag_vib;
  logic [VIB_LAT-1:0][ADDR_W-1:0] r_tag_idx;

  logic                        w_ret_v;
  logic [ADDR_W-1:0]           w_ret_idx;
  logic                        w_wr_v;
  logic                        w_wr_vib;
  logic [ADDR_W-1:0]           w_wr_idx;
  logic                        w_last_wr;

  assign w_ret_v   = r_ret_v[RD_LAT-1];
  assign w_ret_idx = r_ret_idx[RD_LAT-1];
  assign w_wr_v    = r_tag_v[VIB_LAT-1];
  assign w_wr_vib  = r_tag_vib[VIB_LAT-1];
  assign w_wr_idx  = r_tag_idx[VIB_LAT-1];
  assign w_last_wr = w_wr_v && (w_wr_idx == LAST_IDX);

  // Frame FSM: issues one read per cycle, waits for the last write, pulses LFO step
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_dvb        <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_lfo_step   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_lfo_step   <= 1'b0;
      if (i_sample_clk_en && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_sample_clk_en) begin
            r_state   <= S_ISSUE;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
            r_dvb     <= i_dvb;
            r_busy    <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (r_rd_addr == LAST_IDX) begin
            r_state   <= S_DRAIN;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
          end else begin
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (w_last_wr) begin
            r_state      <= S_DONE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
            r_lfo_step   <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Delay read strobe and index until the register file returns data
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ret_v   <= '0;
      r_ret_idx <= '0;
    end else begin
      r_ret_v   <= RD_LAT'({r_ret_v, r_rd_en});
      r_ret_idx <= (RD_LAT * ADDR_W)'({r_ret_idx, r_rd_addr});
    end
  end

  // Capture returned operand; operand outputs hold their value between frames
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_v    <= 1'b0;
      r_s1_idx  <= '0;
      r_s1_vib  <= 1'b0;
      r_s1_dvb  <= 1'b0;
      r_s1_fnum <= '0;
    end else begin
      r_s1_v <= w_ret_v;
      if (w_ret_v) begin
        r_s1_idx  <= w_ret_idx;
        r_s1_vib  <= i_reg_rd_vib;
        r_s1_dvb  <= r_dvb;
        r_s1_fnum <= i_reg_rd_fnum;
      end
    end
  end

  // Carry index and VIB bit alongside the datapath so they land with vib_val
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tag_v   <= '0;
      r_tag_vib <= '0;
      r_tag_idx <= '0;
    end else begin
      r_tag_v   <= VIB_LAT'({r_tag_v, r_s1_v});
      r_tag_vib <= VIB_LAT'({r_tag_vib, r_s1_vib});
      r_tag_idx <= (VIB_LAT * ADDR_W)'({r_tag_idx, r_s1_idx});
    end
  end

  assign o_reg_rd_en    = r_rd_en;
  assign o_reg_rd_addr  = r_rd_addr;
  assign o_vib_fnum     = r_s1_fnum;
  assign o_vib_dvb      = r_s1_dvb;
  assign o_vib_lfo_step = r_lfo_step;
  assign o_res_wr_en    = w_wr_v;
  assign o_res_wr_addr  = w_wr_idx;
  // vib_val arrives from the external datapath in the same cycle as its tag
  assign o_res_wr_data  = (w_wr_v && w_wr_vib) ? i_vib_val : '0;
  assign o_busy         = r_busy;
  assign o_frame_done   = r_frame_done;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_opl3_vib_sequencer.sv
// Bench for opl3_vib_sequencer: register-file and vibrato-datapath models
// around the DUT, with a scoreboard of expected result-buffer writes.
module tb_opl3_vib_sequencer;

  localparam int NUM_OPS   = 36;
  localparam int RD_LAT    = 1;
  localparam int VIB_LAT   = 2;
  localparam int FRAME_LEN = NUM_OPS + RD_LAT + VIB_LAT + 2;
  localparam int WR_LAT    = RD_LAT + 1 + VIB_LAT;

  typedef struct {
    logic [5:0] addr;
    logic [3:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_clk_en;
  logic       dvb;
  logic       reg_rd_en;
  logic [5:0] reg_rd_addr;
  logic [9:0] reg_rd_fnum;
  logic       reg_rd_vib;
  logic [9:0] vib_fnum;
  logic       vib_dvb;
  logic       vib_lfo_step;
  logic [3:0] vib_val;
  logic       res_wr_en;
  logic [5:0] res_wr_addr;
  logic [3:0] res_wr_data;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  logic [9:0] mem_fnum [NUM_OPS];
  logic       mem_vib  [NUM_OPS];
  logic [3:0] dp_stage;
  logic [2:0] lfo_cnt;
  logic       frame_dvb;

  exp_t sb[$];
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_err     = 0;
  int   wr_cnt    = 0;
  int   done_cnt  = 0;
  int   lfo_steps = 0;
  int   rd_next   = 0;

  opl3_vib_sequencer dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_sample_clk_en(sample_clk_en),
    .i_dvb          (dvb),
    .o_reg_rd_en    (reg_rd_en),
    .o_reg_rd_addr  (reg_rd_addr),
    .i_reg_rd_fnum  (reg_rd_fnum),
    .i_reg_rd_vib   (reg_rd_vib),
    .o_vib_fnum     (vib_fnum),
    .o_vib_dvb      (vib_dvb),
    .o_vib_lfo_step (vib_lfo_step),
    .i_vib_val      (vib_val),
    .o_res_wr_en    (res_wr_en),
    .o_res_wr_addr  (res_wr_addr),
    .o_res_wr_data  (res_wr_data),
    .o_busy         (busy),
    .o_frame_done   (frame_done),
    .o_overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Simplified vibrato: delta from fnum MSBs, halved for dvb=0 and odd phases, inverted for phases 4..7
  function automatic logic [3:0] vib_model(input logic [9:0] f, input logic d, input logic [2:0] ph);
    logic [2:0] m;
    m = f[9:7];
    if (!d) m = m >> 1;
    if (ph[0]) m = m >> 1;
    return ph[2] ? ~{1'b0, m} : {1'b0, m};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Register file with one cycle read latency
  always @(posedge clk) begin
    if (reg_rd_en) begin
      reg_rd_fnum <= mem_fnum[reg_rd_addr];
      reg_rd_vib  <= mem_vib[reg_rd_addr];
    end
  end

  // Two-stage vibrato datapath; LFO phase advances on each step pulse
  always @(posedge clk) begin
    dp_stage <= vib_model(vib_fnum, vib_dvb, lfo_cnt);
    vib_val  <= dp_stage;
    if (reset) lfo_cnt <= 3'd0;
    else if (vib_lfo_step) lfo_cnt <= lfo_cnt + 3'd1;
  end

  // Monitor: push expectations at each read, pop and compare at each write
  always @(negedge clk) begin
    exp_t e;
    if (res_wr_en) begin
      chk("wr_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", 32'(res_wr_addr), 32'(e.addr));
        chk("wr_data", 32'(res_wr_data), 32'(e.data));
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
      wr_cnt++;
    end
    if (reg_rd_en) begin
      chk("rd_addr", 32'(reg_rd_addr), 32'(rd_next));
      e.addr = reg_rd_addr;
      e.data = mem_vib[reg_rd_addr] ? vib_model(mem_fnum[reg_rd_addr], frame_dvb, lfo_cnt) : 4'd0;
      e.cyc  = cyc + WR_LAT;
      sb.push_back(e);
      rd_next = (rd_next == NUM_OPS - 1) ? 0 : rd_next + 1;
    end
    if (vib_lfo_step) begin
      lfo_steps++;
      chk("lfo_in_done", 32'(frame_done), 32'd1);
      chk("lfo_not_busy", 32'(busy), 32'd0);
    end
    if (frame_done) done_cnt++;
    if (reset) begin
      sb.delete();
      rd_next = 0;
    end
  end

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Start a frame; optionally raise sample_clk_en again at frame cycle extra_at
  task automatic run_frame(input logic d, input int extra_at);
    int wr0;
    int dn0;
    int lf0;
    int done_t;
    wr0 = wr_cnt;
    dn0 = done_cnt;
    lf0 = lfo_steps;
    done_t = 0;
    frame_dvb = d;
    dvb = d;
    sample_clk_en = 1'b1;
    @(posedge clk);
    #1 sample_clk_en = 1'b0;
    dvb = ~d;
    for (int t = 1; t <= FRAME_LEN + 20; t++) begin
      if (t > 1) begin
        @(posedge clk);
        #1;
      end
      sample_clk_en = (t == extra_at);
      @(negedge clk);
      if (t == 1) begin
        chk("busy_start", 32'(busy), 32'd1);
        chk("rd_en_start", 32'(reg_rd_en), 32'd1);
      end
      if (frame_done) begin
        done_t = t;
        break;
      end
    end
    @(posedge clk);
    #1 sample_clk_en = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rd_en", 32'(reg_rd_en), 32'd0);
    chk("frame_len", 32'(done_t), 32'(FRAME_LEN));
    chk("wr_count", 32'(wr_cnt - wr0), 32'(NUM_OPS));
    chk("done_count", 32'(done_cnt - dn0), 32'd1);
    chk("lfo_count", 32'(lfo_steps - lf0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int l0;
    reset = 1'b1;
    sample_clk_en = 1'b0;
    dvb = 1'b0;
    frame_dvb = 1'b0;
    for (int k = 0; k < NUM_OPS; k++) begin
      mem_fnum[k] = 10'h380;
      mem_vib[k]  = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(reg_rd_en), 32'd0);
    chk("rst_wr_en", 32'(res_wr_en), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_lfo", 32'(vib_lfo_step), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Uniform operators, dvb=1, LFO phase 0
    run_frame(1'b1, -1);
    chk("t1_overrun", 32'(overrun), 32'd0);

    // Operator 5 with VIB off, both depth settings
    pulse_reset();
    mem_vib[5] = 1'b0;
    run_frame(1'b0, -1);
    run_frame(1'b1, -1);
    mem_vib[5] = 1'b1;

    // Extra strobe mid-frame is ignored but flagged
    pulse_reset();
    run_frame(1'b1, 10);
    chk("t3_overrun", 32'(overrun), 32'd1);

    // Extra strobe in the DONE cycle is also an overrun and starts nothing
    pulse_reset();
    run_frame(1'b1, FRAME_LEN);
    chk("done_overrun", 32'(overrun), 32'd1);

    // Reset and strobe together: reset wins
    reset = 1'b1;
    sample_clk_en = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sample_clk_en = 1'b0;
    @(negedge clk);
    chk("rst_win_busy", 32'(busy), 32'd0);
    chk("rst_win_rd_en", 32'(reg_rd_en), 32'd0);
    chk("rst_win_overrun", 32'(overrun), 32'd0);

    // Several frames walk the LFO through all phases including inverted ones
    l0 = lfo_steps;
    for (int f = 0; f < 9; f++) run_frame(1'b1, -1);
    chk("lfo_total", 32'(lfo_steps - l0), 32'd9);

    // Reset at cycle 20 of a frame aborts it cleanly
    frame_dvb = 1'b1;
    dvb = 1'b1;
    sample_clk_en = 1'b1;
    @(posedge clk);
    #1 sample_clk_en = 1'b0;
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr_en", 32'(res_wr_en), 32'd0);
    chk("abort_wr_data", 32'(res_wr_data), 32'd0);
    chk("abort_rd_en", 32'(reg_rd_en), 32'd0);
    chk("abort_vib_fnum", 32'(vib_fnum), 32'd0);
    chk("abort_done", 32'(frame_done), 32'd0);
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_wr", 32'(res_wr_en), 32'd0);
    end
    run_frame(1'b1, -1);

    // Distinct fnum per operator checks tag/data alignment
    for (int k = 0; k < NUM_OPS; k++) begin
      mem_fnum[k] = 10'((k * 'h80) & 'h3FF);
      mem_vib[k]  = ((k % 7) != 3);
    end
    run_frame(1'b1, -1);
    run_frame(1'b0, -1);
    run_frame(1'b1, -1);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
